// File: rtl/alu_arb_pkg.sv
// Shared types for the ALU arbiter: op encodings, FSM states, stats width.
package alu_arb_pkg;

  localparam int unsigned STAT_W = 16;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_AND = 2'b10,
    OP_OR  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_ISSUE = 2'b01,
    S_WAIT  = 2'b10,
    S_RESP  = 2'b11
  } state_e;

endpackage

// File: rtl/alu_arbiter_rr_pick.sv
// Combinational round-robin picker: first valid index at or above ptr,
// wrapping modulo N. Produces a one-hot grant, its index and an any flag.
module rr_pick #(
  parameter int unsigned N  = 4,
  parameter int unsigned IW = $clog2(N)
) (
  input  logic [N-1:0]  valid,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx,
  output logic          any
);

  logic [IW-1:0] cand;

  // Scan candidates in priority order starting at ptr; first hit wins.
  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    cand  = '0;
    for (int unsigned k = 0; k < N; k++) begin
      cand = IW'((32'(ptr) + k) % N);
      if (!any && valid[cand]) begin
        any         = 1'b1;
        idx         = cand;
        grant[cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one external add/sub/logic ALU between NUM_REQ requesters.
// Round-robin grant, one op in flight, tagged response with timeout error.
// Optional build macro ALU_ARB_STATS_EN adds per-requester saturating grant
// counters readable through stat_sel/stat_count (1-cycle registered read).
module alu_arbiter
  import alu_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ     = 4,
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned TIMEOUT_CYC = 15
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_REQ-1:0]          req_valid,
  output logic [NUM_REQ-1:0]          req_ready,
  input  logic [2*NUM_REQ-1:0]        req_op,
  input  logic [NUM_REQ*DATA_W-1:0]   req_a,
  input  logic [NUM_REQ*DATA_W-1:0]   req_b,
  output logic                        alu_valid,
  output logic [1:0]                  alu_op,
  output logic [DATA_W-1:0]           alu_a,
  output logic [DATA_W-1:0]           alu_b,
  input  logic                        alu_done,
  input  logic [DATA_W:0]             alu_result,
  output logic                        rsp_valid,
  input  logic                        rsp_ready,
  output logic [$clog2(NUM_REQ)-1:0]  rsp_id,
  output logic [DATA_W:0]             rsp_data,
  output logic                        rsp_err,
  input  logic [$clog2(NUM_REQ)-1:0]  stat_sel,
  output logic [STAT_W-1:0]           stat_count
);

  localparam int unsigned IW = $clog2(NUM_REQ);

  state_e              state, state_nx;
  logic [IW-1:0]       rr_ptr;
  logic [7:0]          tcnt;
  logic                expire;
  op_e                 op_q;
  logic [DATA_W-1:0]   a_q, b_q;
  logic [IW-1:0]       id_q;
  logic [DATA_W:0]     data_q;
  logic                err_q;
  logic [IW-1:0]       next_ptr;

  logic [NUM_REQ-1:0]  pick_grant;
  logic [IW-1:0]       pick_idx;
  logic                pick_any;
  logic [1:0]          sel_op;
  logic [DATA_W-1:0]   sel_a, sel_b;

  rr_pick #(
    .N  (NUM_REQ),
    .IW (IW)
  ) u_pick (
    .valid (req_valid),
    .ptr   (rr_ptr),
    .grant (pick_grant),
    .idx   (pick_idx),
    .any   (pick_any)
  );

  // Operand mux for the requester the picker selected.
  always_comb begin
    sel_op = '0;
    sel_a  = '0;
    sel_b  = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (pick_idx == IW'(i)) begin
        sel_op = req_op[2*i +: 2];
        sel_a  = req_a[i*DATA_W +: DATA_W];
        sel_b  = req_b[i*DATA_W +: DATA_W];
      end
    end
  end

  // Expiry is the WAIT cycle on which the counter would reach TIMEOUT_CYC.
  assign expire   = (tcnt == 8'(TIMEOUT_CYC - 1));
  assign next_ptr = (id_q == IW'(NUM_REQ - 1)) ? '0 : id_q + IW'(1);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  // Next-state decode; alu_done takes priority over expiry.
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (pick_any) state_nx = S_ISSUE;
      S_ISSUE: state_nx = S_WAIT;
      S_WAIT:  if (alu_done || expire) state_nx = S_RESP;
      S_RESP:  if (rsp_ready) state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // Handshake outputs decoded from state; all held low while in reset.
  always_comb begin
    req_ready = '0;
    alu_valid = 1'b0;
    rsp_valid = 1'b0;
    if (!rst) begin
      case (state)
        S_IDLE:  req_ready = pick_grant;
        S_ISSUE: alu_valid = 1'b1;
        S_RESP:  rsp_valid = 1'b1;
        default: ;
      endcase
    end
  end

  // Datapath: latch request at grant, result/err in WAIT, pointer on response.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr <= '0;
      tcnt   <= '0;
      op_q   <= OP_ADD;
      a_q    <= '0;
      b_q    <= '0;
      id_q   <= '0;
      data_q <= '0;
      err_q  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (pick_any) begin
            op_q <= op_e'(sel_op);
            a_q  <= sel_a;
            b_q  <= sel_b;
            id_q <= pick_idx;
          end
        end
        S_ISSUE: tcnt <= '0;
        S_WAIT: begin
          if (alu_done) begin
            data_q <= alu_result;
            err_q  <= 1'b0;
          end else begin
            tcnt <= tcnt + 8'd1;
            if (expire) begin
              data_q <= '0;
              err_q  <= 1'b1;
            end
          end
        end
        S_RESP: begin
          if (rsp_ready) rr_ptr <= next_ptr;
        end
        default: ;
      endcase
    end
  end

  assign alu_op   = op_q;
  assign alu_a    = a_q;
  assign alu_b    = b_q;
  assign rsp_id   = id_q;
  assign rsp_data = data_q;
  assign rsp_err  = err_q;

`ifdef ALU_ARB_STATS_EN
  logic [STAT_W-1:0] grant_cnt [NUM_REQ];

  // Saturating per-requester grant counters with registered readback.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < NUM_REQ; i++) grant_cnt[i] <= '0;
      stat_count <= '0;
    end else begin
      if (state == S_IDLE && pick_any && grant_cnt[pick_idx] != '1)
        grant_cnt[pick_idx] <= grant_cnt[pick_idx] + STAT_W'(1);
      stat_count <= (32'(stat_sel) < NUM_REQ) ? grant_cnt[stat_sel] : '0;
    end
  end
`else
  logic unused_stat_sel;
  assign unused_stat_sel = ^stat_sel;
  assign stat_count      = '0;
`endif

endmodule
